// File: rtl/parking_gate_ctrl.sv
// Shared-lane barrier controller: arbitrates entry/exit requests, opens the gate in the
// granted direction, closes on passage or timeout, and tracks lot occupancy.
module parking_gate_ctrl #(
  parameter int CAPACITY     = 15,
  parameter int CNT_W        = 4,
  parameter int OPEN_TIMEOUT = 1000,
  parameter int GUARD        = 50,
  parameter int TO_W         = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             entrada,
  input  logic             salida,
  output logic             gate_open,
  output logic             dir_in,
  output logic             dir_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             timeout,
  output logic             dir_err
);

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSE} state_t;

  localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);
  localparam logic [TO_W-1:0]  OPEN_LAST = TO_W'(OPEN_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  GUARD_LAST = TO_W'(GUARD - 1);
  localparam logic             LG_IN     = 1'b0;
  localparam logic             LG_OUT    = 1'b1;

  state_t          state;
  logic [TO_W-1:0] timer;
  logic            last_grant;

  logic             elig_in;
  logic             elig_out;
  logic             pass_ok;
  logic             err_next;
  logic [CNT_W-1:0] cnt_next;

  assign elig_in  = req_in && !full;
  assign elig_out = req_out && !empty;

  // Passage decoding: a pulse only counts in the matching open state and within range;
  // anything else (wrong state, simultaneous pulses, saturation) is flagged instead.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    cnt_next = count;
    err_next = 1'b0;
    pass_ok  = 1'b0;
    if (entrada && salida) begin
      err_next = 1'b1;
    end else if (entrada) begin
      if (state == OPEN_IN && count != CAP) begin
        cnt_next = count + CNT_W'(1);
        pass_ok  = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end else if (salida) begin
      if (state == OPEN_OUT && count != '0) begin
        cnt_next = count - CNT_W'(1);
        pass_ok  = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      last_grant <= LG_IN;
      gate_open  <= 1'b0;
      dir_in     <= 1'b0;
      dir_out    <= 1'b0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      timeout    <= 1'b0;
      dir_err    <= 1'b0;
    end else begin
      count   <= cnt_next;
      full    <= (cnt_next == CAP);
      empty   <= (cnt_next == '0);
      dir_err <= err_next;
      timeout <= 1'b0;

      case (state)
        IDLE: begin
          // With both eligible, round-robin favours the side not served last.
          if (elig_in && (!elig_out || last_grant == LG_OUT)) begin
            state      <= OPEN_IN;
            last_grant <= LG_IN;
            timer      <= '0;
            gate_open  <= 1'b1;
            dir_in     <= 1'b1;
            dir_out    <= 1'b0;
          end else if (elig_out) begin
            state      <= OPEN_OUT;
            last_grant <= LG_OUT;
            timer      <= '0;
            gate_open  <= 1'b1;
            dir_in     <= 1'b0;
            dir_out    <= 1'b1;
          end
        end

        OPEN_IN, OPEN_OUT: begin
          if (pass_ok || timer == OPEN_LAST) begin
            timeout   <= !pass_ok;
            state     <= CLOSE;
            timer     <= '0;
            gate_open <= 1'b0;
            dir_in    <= 1'b0;
            dir_out   <= 1'b0;
          end else begin
            timer <= timer + TO_W'(1);
          end
        end

        CLOSE: begin
          if (timer == GUARD_LAST) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + TO_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          timer     <= '0;
          gate_open <= 1'b0;
          dir_in    <= 1'b0;
          dir_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Controller for the single shared barrier lane of the parking-lot system. It arbitrates between entry and exit requests and opens the barrier in the granted direction. It closes the barrier when the car detector reports a completed passage or a timeout expires, and it maintains the occupancy count with full/empty flags. It sits downstream of the car detector (`entrada`/`salida` one-cycle pulses) and upstream of the barrier actuator and display.

## Interface
Parameters:
- `CAPACITY`, default 15: maximum number of cars.
- `CNT_W`, default 4: width of `count`; must hold `CAPACITY`.
- `OPEN_TIMEOUT`, default 1000: maximum number of cycles the gate stays open waiting for a passage.
- `GUARD`, default 50: number of cycles the gate stays closed after each passage or timeout.
- `TO_W`, default 10: timer width; must hold `max(OPEN_TIMEOUT, GUARD)`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `req_in`  in  1  level: car waiting at entry.
- `req_out`  in  1  level: car waiting at exit.
- `entrada`  in  1  1-cycle pulse: car completed an inward passage.
- `salida`  in  1  1-cycle pulse: car completed an outward passage.
- `gate_open`  out  1  barrier raise command.
- `dir_in`  out  1  open gate is granted to entry.
- `dir_out`  out  1  open gate is granted to exit.
- `count`  out  CNT_W  current occupancy.
- `full`  out  1  `count == CAPACITY`.
- `empty`  out  1  `count == 0`.
- `timeout`  out  1  1-cycle pulse: open window expired with no passage.
- `dir_err`  out  1  1-cycle pulse: unexpected or conflicting passage pulse.

## Operation
- All outputs are registered.
- Reset values:
  - `gate_open`, `dir_in`, `dir_out`, `timeout`, `dir_err`, `full` = 0.
  - `count` = 0; `empty` = 1.
  - state = IDLE; timer = 0; `last_grant` = IN.
- State IDLE:
  - Entry is eligible when `req_in && !full`. Exit is eligible when `req_out && !empty`.
  - One eligible request: grant it.
  - Both eligible: grant the direction opposite to `last_grant` (round-robin). After reset, exit wins first.
  - On grant: go to OPEN_IN or OPEN_OUT, update `last_grant`, clear the timer.
  - No eligible request: stay in IDLE.
- State OPEN_IN (`gate_open`=1, `dir_in`=1):
  - `entrada` alone: `count`+1, go to CLOSE.
  - `salida` alone: pulse `dir_err`, `count` unchanged, stay in OPEN_IN.
  - Timer reaches `OPEN_TIMEOUT`-1 with no passage: pulse `timeout`, go to CLOSE.
- State OPEN_OUT: mirror of OPEN_IN. `salida` gives `count`-1; `entrada` gives `dir_err`.
- State CLOSE (`gate_open`=0, dir outputs 0):
  - Holds for `GUARD` cycles, then goes to IDLE.
  - Requests are ignored in CLOSE.
- Passage pulse rules:
  - `entrada` and `salida` in the same cycle: both ignored, pulse `dir_err`, no state change.
  - Any passage pulse in IDLE or CLOSE: pulse `dir_err`, `count` unchanged.
- Arithmetic:
  - `count` saturates at 0 and at `CAPACITY`. A pulse that would overflow or underflow is dropped and pulses `dir_err`.
  - `full` and `empty` are recomputed from the next value of `count`, so they change in the same cycle as `count`.
- Passage and timeout in the same cycle: the passage wins. `count` updates, no `timeout` pulse.
- Reset asserted mid-operation: immediate return to reset values. The gate drops asynchronously.

## Timing
- Request to grant latency is 1 cycle: request seen high at edge N gives `gate_open`/`dir_*` high after edge N+1's update, i.e. visible in cycle N+1.
- Passage pulse in cycle N:
  - `count`, `full`, `empty` update in cycle N+1.
  - `gate_open` falls in cycle N+1.
  - CLOSE lasts exactly `GUARD` cycles (N+1 … N+GUARD).
  - IDLE in cycle N+GUARD+1.
  - The earliest new grant is visible in cycle N+GUARD+2.
- Timeout: with `gate_open` first high in cycle M and no passage, `timeout` pulses in and `gate_open` falls in cycle M+`OPEN_TIMEOUT`.
- `timeout` and `dir_err` are high for exactly one cycle per event.
- Requests are levels and are not latched. A request dropped before IDLE samples it is lost.

## Test plan
- Reset then idle: outputs at reset values (`empty`=1). `req_out`=1 with `count`=0 gives no grant.
- Single entry, `CAPACITY`=15, `GUARD`=50:
  - `req_in` at cycle 10 gives `gate_open`=1, `dir_in`=1 at cycle 11.
  - `entrada` at cycle 20 gives `count`=1 and `gate_open`=0 at cycle 21.
  - IDLE again at cycle 71.
- Fill and block: 15 entries give `full`=1. A further `req_in` yields no grant. A held `req_out` gives an exit and `count`=14.
- Contention: `req_in`=`req_out`=1 held with `count`=5.
  - Grants alternate OUT, IN, OUT… `count` sequence is 4, 5, 4.
- Timeout, `OPEN_TIMEOUT`=1000: grant entry, no pulse.
  - `timeout` pulses 1000 cycles after `gate_open` rose.
  - `count` unchanged, CLOSE entered.
- Errors:
  - `salida` during OPEN_IN gives `dir_err` with the gate still open.
  - `entrada`+`salida` together gives `dir_err`.
  - Reset during OPEN_OUT gives `gate_open`=0 immediately and `count`=0.
